// File: rtl/cpu_dbg_pkg.sv
// ---------------------------------------------------------------------------
// cpu_dbg_pkg
// Shared definitions for the CPU step/debug controller:
//   - default parameter values (address widths, counter width, debounce and
//     register-scan timing)
//   - run-mode encodings driven on the controller's mode input
//   - FSM state encodings (plain constants for legacy tools, plus an enum
//     view of the same values for waveform viewers and assertions)
// ---------------------------------------------------------------------------
package cpu_dbg_pkg;

  // Default parameter values
  localparam int unsigned DEF_AW       = 32;
  localparam int unsigned DEF_RF_AW    = 5;
  localparam int unsigned DEF_CNT_W    = 16;
  localparam logic [19:0] DEF_DEB_CYC  = 20'd500000;
  localparam int unsigned DEF_SCAN_DIV = 24;

  // Run-mode encodings
  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;
  localparam logic [1:0] MODE_RUN   = 2'b11;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_STEP  = 3'd1;
  localparam logic [2:0] ST_BURST = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_STEP  = ST_STEP,
    S_BURST = ST_BURST,
    S_RUN   = ST_RUN,
    S_BREAK = ST_BREAK
  } state_e;

endpackage

// File: rtl/cpu_step_debug_ctrl_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser followed by a stable-count debouncer for a raw
// push-button input.
// Ports:
//   clk      in  clock
//   resetn   in  synchronous active-low reset
//   btn_raw  in  raw asynchronous button level (high = pressed)
//   level    out debounced button level
//   press    out one-clk pulse on each accepted 0->1 transition
// A new level is accepted only after DEB_CYC consecutive synchronised samples
// all differ from the current level; a single sample equal to the current
// level restarts the count.
// ---------------------------------------------------------------------------
module btn_debounce
  import cpu_dbg_pkg::*;
#(
  parameter logic [19:0] DEB_CYC = DEF_DEB_CYC
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  logic [1:0]  sync_q, sync_d;
  logic        level_q, level_d;
  logic        press_q, press_d;
  logic [19:0] cnt_q, cnt_d;
  logic [20:0] cnt_inc;
  logic        sample;

  assign sample  = sync_q[1];
  assign cnt_inc = {1'b0, cnt_q} + 21'd1;

  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sample == level_q) begin
      cnt_d = '0;
    end else if (cnt_inc >= {1'b0, DEB_CYC}) begin
      // This sample completes the run of differing samples: accept it.
      level_d = sample;
      cnt_d   = '0;
      press_d = sample;
    end else begin
      cnt_d = cnt_inc[19:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/cpu_step_debug_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_step_debug_ctrl
// Board-level run/step controller for a soft CPU: gates the CPU clock enable
// according to a run mode and a debounced step button, counts granted CPU
// cycles, scans a register-file display address and keeps a memory watch
// address.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   btn_step                    raw step button (high = pressed)
//   mode[1:0]                   00 HALT, 01 STEP, 10 BURST, 11 RUN
//   burst_len[CNT_W-1:0]        CPU cycles per BURST press (0 behaves as 1)
//   cpu_pc, bp_addr, bp_valid   breakpoint compare inputs
//   mem_addr_ld/in/inc          watch-address load / +4 step (load wins)
//   cpu_clk_en                  CPU clock-gate enable (held 1 during reset so
//                               the CPU sees its own synchronous reset)
//   halted                      CPU not advancing (0 during reset)
//   bp_hit                      sticky breakpoint flag
//   step_cnt                    CPU cycles granted since reset
//   rf_scan_addr                register-file scan address
//   mem_addr                    memory watch address
// Build option: define BREAKPOINT_EN to include the breakpoint compare, the
// BREAK state and the bp_hit flag; otherwise bp_hit is tied 0 and the
// breakpoint inputs are ignored.
// ---------------------------------------------------------------------------
module cpu_step_debug_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned RF_AW    = DEF_RF_AW,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter logic [19:0] DEB_CYC  = DEF_DEB_CYC,
  parameter int unsigned SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             btn_step,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [AW-1:0]    cpu_pc,
  input  logic [AW-1:0]    bp_addr,
  input  logic             bp_valid,
  input  logic             mem_addr_ld,
  input  logic [AW-1:0]    mem_addr_in,
  input  logic             mem_addr_inc,
  output logic             cpu_clk_en,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] step_cnt,
  output logic [RF_AW-1:0] rf_scan_addr,
  output logic [AW-1:0]    mem_addr
);

  logic btn_level;
  logic btn_press;

  btn_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_btn_debounce (
    .clk     (clk),
    .resetn  (resetn),
    .btn_raw (btn_step),
    .level   (btn_level),
    .press   (btn_press)
  );

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic [CNT_W-1:0]    step_cnt_q, step_cnt_d;
  logic [SCAN_DIV-1:0] scan_div_q, scan_div_d;
  logic [RF_AW-1:0]    rf_scan_q, rf_scan_d;
  logic [AW-1:0]       mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]    burst_load;
  logic                run_en;

  assign burst_load = (burst_len == '0) ? CNT_W'(1) : burst_len;

`ifdef BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d;
  logic bp_match;
  logic unused_ok;

  assign bp_match  = bp_valid && (cpu_pc == bp_addr);
  assign unused_ok = &{1'b0, btn_level};
`else
  logic unused_ok;

  assign unused_ok = &{1'b0, btn_level, cpu_pc, bp_addr, bp_valid};
`endif

  // Run-control FSM. run_en is the enable granted to the CPU this clk when
  // out of reset; presses outside IDLE/BREAK simply fall on the floor.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    run_en      = 1'b0;
`ifdef BREAKPOINT_EN
    bp_hit_d    = bp_hit_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mode == MODE_RUN) begin
          state_d = ST_RUN;
        end else if (btn_press && (mode == MODE_STEP)) begin
          state_d = ST_STEP;
        end else if (btn_press && (mode == MODE_BURST)) begin
          state_d     = ST_BURST;
          remaining_d = burst_load;
        end
      end
      ST_STEP: begin
        run_en  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_BURST: begin
        // Mode is deliberately not looked at: a burst always runs to the end.
        run_en      = 1'b1;
        remaining_d = remaining_q - CNT_W'(1);
        if (remaining_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
        end
`ifdef BREAKPOINT_EN
        if (bp_match) begin
          run_en   = 1'b0;
          state_d  = ST_BREAK;
          bp_hit_d = 1'b1;
        end
`endif
      end
      ST_RUN: begin
        run_en = 1'b1;
        if (mode != MODE_RUN) begin
          state_d = ST_IDLE;
        end
`ifdef BREAKPOINT_EN
        if (bp_match) begin
          run_en   = 1'b0;
          state_d  = ST_BREAK;
          bp_hit_d = 1'b1;
        end
`endif
      end
`ifdef BREAKPOINT_EN
      ST_BREAK: begin
        // Only a single step moves past a breakpoint; STEP is not compared,
        // so the CPU can leave the breakpoint address.
        if (btn_press && (mode == MODE_STEP)) begin
          state_d  = ST_STEP;
          bp_hit_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Counters and watch address
  always_comb begin
    step_cnt_d = step_cnt_q + CNT_W'(run_en);
    scan_div_d = scan_div_q + SCAN_DIV'(1);
    rf_scan_d  = (&scan_div_q) ? (rf_scan_q + RF_AW'(1)) : rf_scan_q;
    mem_addr_d = mem_addr_q;
    if (mem_addr_ld) begin
      mem_addr_d = mem_addr_in;
    end else if (mem_addr_inc) begin
      mem_addr_d = mem_addr_q + AW'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      step_cnt_q  <= '0;
      scan_div_q  <= '0;
      rf_scan_q   <= '0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      step_cnt_q  <= step_cnt_d;
      scan_div_q  <= scan_div_d;
      rf_scan_q   <= rf_scan_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

`ifdef BREAKPOINT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bp_hit_q <= 1'b0;
    end else begin
      bp_hit_q <= bp_hit_d;
    end
  end

  assign bp_hit = bp_hit_q;
`else
  assign bp_hit = 1'b0;
`endif

  // The CPU clock runs through reset so the CPU's own synchronous reset lands.
  assign cpu_clk_en   = ~resetn | run_en;
  assign halted       = resetn & ~run_en;
  assign step_cnt     = step_cnt_q;
  assign rf_scan_addr = rf_scan_q;
  assign mem_addr     = mem_addr_q;

endmodule

// File: tb/tb_cpu_step_debug_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_step_debug_ctrl
// Self-checking bench: every clk the DUT outputs are compared with a
// behavioural model (grant budget / run flag / break flag, a sample-window
// debouncer and a free-running cycle count), followed by randomized traffic.
// Works with and without BREAKPOINT_EN.
// ---------------------------------------------------------------------------
module tb_cpu_step_debug_ctrl;

  localparam int unsigned AW       = 32;
  localparam int unsigned RF_AW    = 5;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned SCAN_DIV = 1;
  localparam logic [19:0] DEB_CYC  = 20'd4;
  localparam int          DEB      = 4;
`ifdef BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  logic             clk          = 1'b0;
  logic             resetn       = 1'b0;
  logic             btn_step     = 1'b0;
  logic [1:0]       mode         = 2'b00;
  logic [CNT_W-1:0] burst_len    = '0;
  logic [AW-1:0]    cpu_pc       = '0;
  logic [AW-1:0]    bp_addr      = '0;
  logic             bp_valid     = 1'b0;
  logic             mem_addr_ld  = 1'b0;
  logic [AW-1:0]    mem_addr_in  = '0;
  logic             mem_addr_inc = 1'b0;
  logic             cpu_clk_en;
  logic             halted;
  logic             bp_hit;
  logic [CNT_W-1:0] step_cnt;
  logic [RF_AW-1:0] rf_scan_addr;
  logic [AW-1:0]    mem_addr;

  cpu_step_debug_ctrl #(
    .AW       (AW),
    .RF_AW    (RF_AW),
    .CNT_W    (CNT_W),
    .DEB_CYC  (DEB_CYC),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .btn_step     (btn_step),
    .mode         (mode),
    .burst_len    (burst_len),
    .cpu_pc       (cpu_pc),
    .bp_addr      (bp_addr),
    .bp_valid     (bp_valid),
    .mem_addr_ld  (mem_addr_ld),
    .mem_addr_in  (mem_addr_in),
    .mem_addr_inc (mem_addr_inc),
    .cpu_clk_en   (cpu_clk_en),
    .halted       (halted),
    .bp_hit       (bp_hit),
    .step_cnt     (step_cnt),
    .rf_scan_addr (rf_scan_addr),
    .mem_addr     (mem_addr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int               m_grants;   // CPU cycles still owed to a step or burst
  bit               m_burst;    // owed cycles belong to a burst (bp-checked)
  bit               m_run;
  bit               m_break;
  bit               m_bp_hit;
  logic [CNT_W-1:0] m_steps;
  int               m_cycles;   // clks out of reset, drives the scan address
  logic [AW-1:0]    m_mem;
  bit               m_s1, m_s2; // button delay through the synchroniser
  bit               m_level;
  bit               m_press;
  bit               m_last_en;
  bit               hist[$];    // recent synchronised samples

  // Directed-scenario observation
  int en_seen;
  int cur_run;
  int max_run;
  bit pc_follow = 1'b0;
  logic [CNT_W-1:0] base_steps;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_bp();
    return BP_EN && bp_valid && (cpu_pc == bp_addr);
  endfunction

  function automatic bit exp_en();
    if (!resetn) return 1'b1;
    if (m_run) return !exp_bp();
    if (m_grants > 0) return !(m_burst && exp_bp());
    return 1'b0;
  endfunction

  // Advance the model across one rising edge using the pre-edge inputs.
  task automatic model_step();
    bit en;
    bit bp;
    bit smp;
    bit all_new;
    if (!resetn) begin
      m_grants = 0; m_burst = 0; m_run = 0; m_break = 0; m_bp_hit = 0;
      m_steps = '0; m_cycles = 0; m_mem = '0;
      m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0; m_last_en = 0;
      hist.delete();
      return;
    end
    en = exp_en();
    bp = exp_bp();
    m_last_en = en;
    if (m_run) begin
      if (bp) begin
        m_run = 0; m_break = 1; m_bp_hit = 1;
      end else if (mode != 2'b11) begin
        m_run = 0;
      end
    end else if (m_grants > 0) begin
      if (m_burst && bp) begin
        m_grants = 0; m_break = 1; m_bp_hit = 1;
      end else begin
        m_grants--;
      end
    end else if (m_break) begin
      if (m_press && mode == 2'b01) begin
        m_break = 0; m_bp_hit = 0; m_grants = 1; m_burst = 0;
      end
    end else begin
      if (mode == 2'b11) begin
        m_run = 1;
      end else if (m_press && mode == 2'b01) begin
        m_grants = 1; m_burst = 0;
      end else if (m_press && mode == 2'b10) begin
        m_grants = (burst_len == '0) ? 1 : int'(burst_len);
        m_burst  = 1;
      end
    end
    if (en) m_steps = m_steps + CNT_W'(1);
    m_cycles++;
    if (mem_addr_ld) m_mem = mem_addr_in;
    else if (mem_addr_inc) m_mem = m_mem + 32'd4;
    // Debouncer: level flips once the last DEB samples all disagree with it.
    smp  = m_s2;
    m_s2 = m_s1;
    m_s1 = btn_step;
    m_press = 0;
    hist.push_back(smp);
    if (hist.size() > DEB) void'(hist.pop_front());
    all_new = 1'b1;
    foreach (hist[i]) if (hist[i] == m_level) all_new = 1'b0;
    if (hist.size() == DEB && all_new) begin
      m_level = !m_level;
      m_press = m_level;
      hist.delete();
    end
  endtask

  task automatic check_outputs();
    bit en;
    en = exp_en();
    check_val("cpu_clk_en", 32'(cpu_clk_en), 32'(en));
    check_val("halted", 32'(halted), 32'(resetn && !en));
    check_val("bp_hit", 32'(bp_hit), 32'(m_bp_hit));
    check_val("step_cnt", 32'(step_cnt), 32'(m_steps));
    check_val("rf_scan_addr", 32'(rf_scan_addr), 32'((m_cycles >> SCAN_DIV) % 32));
    check_val("mem_addr", mem_addr, m_mem);
  endtask

  // One clk: check at the falling edge, update the model at the rising edge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    if (cpu_clk_en) begin
      en_seen++;
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
    end else begin
      cur_run = 0;
    end
    @(posedge clk);
    model_step();
    if (pc_follow && m_last_en) cpu_pc = cpu_pc + 32'd4;
    #1;
  endtask

  task automatic push_button(input int hold, input int gap);
    btn_step = 1'b1;
    repeat (hold) cycle();
    btn_step = 1'b0;
    repeat (gap) cycle();
  endtask

  task automatic clear_obs();
    en_seen = 0; cur_run = 0; max_run = 0;
  endtask

  initial begin
    int hold;
    // Bring the DUT out of X before any comparison.
    resetn = 1'b0;
    repeat (2) begin
      @(posedge clk);
      model_step();
      #1;
    end
    repeat (2) cycle();
    check_val("rst_step_cnt", 32'(step_cnt), 32'd0);
    check_val("rst_en", 32'(cpu_clk_en), 32'd1);
    check_val("rst_halted", 32'(halted), 32'd0);
    resetn = 1'b1;
    repeat (3) cycle();
    $display("reset: step_cnt=%0d halted=%0b", step_cnt, halted);

    // Single clean press in STEP mode
    mode = 2'b01;
    clear_obs();
    push_button(10, 12);
    check_val("step_pulses", 32'(en_seen), 32'd1);
    check_val("step_cnt_1", 32'(step_cnt), 32'd1);
    $display("step press: pulses=%0d step_cnt=%0d", en_seen, step_cnt);

    // Ten bounces then a stable press
    clear_obs();
    repeat (10) begin
      btn_step = 1'b1; cycle(); cycle();
      btn_step = 1'b0; cycle(); cycle();
    end
    push_button(10, 12);
    check_val("bounce_pulses", 32'(en_seen), 32'd1);
    check_val("step_cnt_2", 32'(step_cnt), 32'd2);
    $display("bounced press: pulses=%0d step_cnt=%0d", en_seen, step_cnt);

    // Burst of 5; mode drops to HALT mid-burst and must not abort it
    mode = 2'b10;
    burst_len = 16'd5;
    clear_obs();
    btn_step = 1'b1;
    repeat (8) cycle();
    mode = 2'b00;
    repeat (2) cycle();
    btn_step = 1'b0;
    repeat (14) cycle();
    check_val("burst_pulses", 32'(en_seen), 32'd5);
    check_val("burst_consec", 32'(max_run), 32'd5);
    check_val("burst_cnt", 32'(step_cnt), 32'd7);
    $display("burst len=5: pulses=%0d longest=%0d step_cnt=%0d", en_seen, max_run, step_cnt);

    // Burst length 0 behaves as 1
    mode = 2'b10;
    burst_len = '0;
    clear_obs();
    push_button(10, 12);
    check_val("burst0_pulses", 32'(en_seen), 32'd1);
    check_val("burst0_cnt", 32'(step_cnt), 32'd8);
    $display("burst len=0: pulses=%0d step_cnt=%0d", en_seen, step_cnt);

    // RUN for 7 cycles, then a 1-clk reset
    mode = 2'b11;
    clear_obs();
    repeat (8) cycle();
    check_val("run_pulses", 32'(en_seen), 32'd7);
    resetn = 1'b0;
    mode = 2'b00;
    #1;
    check_val("run_rst_en", 32'(cpu_clk_en), 32'd1);
    cycle();
    check_val("run_rst_cnt", 32'(step_cnt), 32'd0);
    resetn = 1'b1;
    cycle();
    check_val("run_rst_halted", 32'(halted), 32'd1);
    check_val("run_rst_en_off", 32'(cpu_clk_en), 32'd0);
    $display("run then reset: run pulses=%0d step_cnt=%0d halted=%0b", en_seen, step_cnt, halted);

    // Breakpoint at 0x10 while running, then single-step past it
    cpu_pc = '0;
    bp_addr = 32'h10;
    bp_valid = 1'b1;
    pc_follow = 1'b1;
    base_steps = m_steps;
    mode = 2'b11;
    repeat (10) cycle();
`ifdef BREAKPOINT_EN
    check_val("bp_hit_set", 32'(bp_hit), 32'd1);
    check_val("bp_en_off", 32'(cpu_clk_en), 32'd0);
    check_val("bp_steps", 32'(step_cnt), 32'(base_steps + 16'd4));
`else
    check_val("bp_hit_tied", 32'(bp_hit), 32'd0);
    check_val("bp_ignored_steps", 32'(step_cnt), 32'(base_steps + 16'd9));
`endif
    mode = 2'b01;
    pc_follow = 1'b0;
    cycle();
    clear_obs();
    push_button(10, 12);
    check_val("bp_step_pulses", 32'(en_seen), 32'd1);
    check_val("bp_hit_clear", 32'(bp_hit), 32'd0);
    $display("breakpoint: pc=0x%08h bp_hit=%0b step pulses=%0d", cpu_pc, bp_hit, en_seen);
    bp_valid = 1'b0;
    mode = 2'b00;

    // Watch address: wrap on +4, load wins over increment
    mem_addr_ld = 1'b1;
    mem_addr_in = 32'hFFFF_FFFC;
    cycle();
    mem_addr_ld = 1'b0;
    mem_addr_inc = 1'b1;
    cycle();
    check_val("mem_wrap", mem_addr, 32'h0);
    mem_addr_ld = 1'b1;
    mem_addr_in = 32'h0000_1234;
    cycle();
    check_val("mem_ld_prio", mem_addr, 32'h0000_1234);
    mem_addr_ld = 1'b0;
    mem_addr_inc = 1'b0;
    $display("mem_addr: load/inc sequence ends at 0x%08h", mem_addr);

    // Register scan wraps 31 -> 0 after 64 clks
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    repeat (62) cycle();
    check_val("scan_31", 32'(rf_scan_addr), 32'd31);
    repeat (2) cycle();
    check_val("scan_wrap", 32'(rf_scan_addr), 32'd0);
    $display("rf scan: wrapped to %0d after 64 clks", rf_scan_addr);

    // Randomized traffic
    repeat (200) begin
      btn_step = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
      burst_len = CNT_W'($urandom_range(0, 6));
      bp_valid  = 1'($urandom_range(0, 1));
      bp_addr   = 32'($urandom_range(0, 3)) * 32'd4;
      hold = int'($urandom_range(1, 9));
      repeat (hold) begin
        cpu_pc       = 32'($urandom_range(0, 7)) * 32'd4;
        mem_addr_ld  = ($urandom_range(0, 7) == 0);
        mem_addr_in  = $urandom;
        mem_addr_inc = 1'($urandom_range(0, 1));
        resetn       = ($urandom_range(0, 149) != 0);
        cycle();
      end
    end
    resetn = 1'b1;
    $display("random traffic: step_cnt=%0d mem_addr=0x%08h", step_cnt, mem_addr);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
